jamma_input_conditioner: RTL and testbench

JAMMA_INPUT_CONDITIONER -- requirements
Module: jamma_input_conditioner

---
 rtl/jamma_input_conditioner.sv | 77 +++++++
 tb/tb_jamma_input_conditioner.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/jamma_input_conditioner.sv
// JAMMA control conditioner: per-bit 2-flop synchronizer, inversion to active-high,
// and an independent stable-count debouncer that emits one-cycle press/release pulses.
// "release" is a reserved word, so the release pulse port is named release_o.
module jamma_input_conditioner #(
  parameter int unsigned DB_CYCLES = 500000,
  parameter int unsigned CNT_W     = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] raw_n,
  output logic [15:0] btn,
  output logic [15:0] press,
  output logic [15:0] release_o,
  output logic        any_press
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic [15:0]      s1_q, s1_d;
  logic [15:0]      s2_q, s2_d;
  logic [15:0]      st_q, st_d;
  logic [15:0]      press_q, press_d;
  logic [15:0]      rel_q, rel_d;
  logic             any_q, any_d;
  logic [CNT_W-1:0] cnt_q [16];
  logic [CNT_W-1:0] cnt_d [16];
  logic [15:0]      s;

  always_comb begin
    s1_d    = raw_n;
    s2_d    = s1_q;
    s       = ~s2_q;
    st_d    = st_q;
    press_d = '0;
    rel_d   = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      cnt_d[i] = '0;
      if (s[i] != st_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          // Accept the new level; the pulse is registered alongside btn.
          st_d[i]    = s[i];
          press_d[i] = s[i];
          rel_d[i]   = ~s[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
    any_d = |press_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= '1;
      s2_q    <= '1;
      st_q    <= '0;
      press_q <= '0;
      rel_q   <= '0;
      any_q   <= 1'b0;
      for (int unsigned i = 0; i < 16; i++) cnt_q[i] <= '0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      st_q    <= st_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      any_q   <= any_d;
      for (int unsigned i = 0; i < 16; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign btn       = st_q;
  assign press     = press_q;
  assign release_o = rel_q;
  assign any_press = any_q;

endmodule

// File: tb/tb_jamma_input_conditioner.sv
// Scoreboard bench for jamma_input_conditioner with DB_CYCLES=4: expectations are
// queued with a target cycle when stimulus is driven and checked at that cycle.
module tb_jamma_input_conditioner;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] raw_n;
  logic [15:0] btn, press, release_o;
  logic        any_press;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int          cyc;
    string       tag;
    logic [15:0] mask;
    logic [15:0] btn;
    logic [15:0] press;
    logic [15:0] rel;
    logic        any;
  } exp_t;

  exp_t sb[$];

  jamma_input_conditioner #(.DB_CYCLES(4), .CNT_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .raw_n     (raw_n),
    .btn       (btn),
    .press     (press),
    .release_o (release_o),
    .any_press (any_press)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  // Queue an expectation for the outputs seen d cycles after the current negedge.
  task automatic push(input int d, input string tag, input logic [15:0] mask,
                      input logic [15:0] b, input logic [15:0] p, input logic [15:0] r,
                      input logic any);
    exp_t e;
    e.cyc = cyc + d; e.tag = tag; e.mask = mask;
    e.btn = b; e.press = p; e.rel = r; e.any = any;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        check({sb[i].tag, "_btn"},   btn & sb[i].mask,       sb[i].btn & sb[i].mask);
        check({sb[i].tag, "_press"}, press & sb[i].mask,     sb[i].press & sb[i].mask);
        check({sb[i].tag, "_rel"},   release_o & sb[i].mask, sb[i].rel & sb[i].mask);
        check({sb[i].tag, "_any"},   {15'd0, any_press},     {15'd0, sb[i].any});
        sb.delete(i);
      end
    end
  end

  localparam logic [15:0] B0 = 16'h0001;
  localparam logic [15:0] B3 = 16'h0008;
  localparam logic [15:0] B5 = 16'h0020;
  localparam logic [15:0] B9 = 16'h0200;

  initial begin
    logic [6:0] bounce;
    rst   = 1'b1;
    raw_n = '1;
    tick(1);
    push(1, "reset", '1, '0, '0, '0, 1'b0);
    tick(2);

    // Release reset with all inputs idle; nothing may move for 100 cycles.
    rst = 1'b0;
    for (int d = 1; d <= 100; d++) push(d, "idle", '1, '0, '0, '0, 1'b0);
    tick(100);

    // Clean press on bit 0.
    raw_n[0] = 1'b0;
    for (int d = 1; d <= 5; d++) push(d, "press0_wait", B0, '0, '0, '0, 1'b0);
    push(6, "press0_edge", B0, B0, B0, '0, 1'b1);
    push(7, "press0_after", B0, B0, '0, '0, 1'b0);
    tick(8);

    // Press then cleanly release bit 9.
    raw_n[9] = 1'b0;
    push(6, "press9_edge", B9, B9, B9, '0, 1'b1);
    tick(8);
    raw_n[9] = 1'b1;
    for (int d = 1; d <= 5; d++) push(d, "rel9_wait", B9, B9, '0, '0, 1'b0);
    push(6, "rel9_edge", B9, '0, '0, B9, 1'b0);
    push(7, "rel9_after", B9, '0, '0, '0, 1'b0);
    tick(8);

    // Bounce on bit 3: low 3, high 1, low 3, high; never accepted.
    bounce = 7'b1110111;
    for (int d = 1; d <= 16; d++) push(d, "bounce3", B3, '0, '0, '0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      raw_n[3] = ~bounce[i];
      tick(1);
    end
    raw_n[3] = 1'b1;
    tick(10);

    // Return to idle, then press everything at once and release everything at once.
    raw_n = '1;
    tick(8);
    raw_n = '0;
    for (int d = 1; d <= 5; d++) push(d, "all_wait", '1, '0, '0, '0, 1'b0);
    push(6, "all_press", '1, '1, '1, '0, 1'b1);
    push(7, "all_hold", '1, '1, '0, '0, 1'b0);
    tick(8);
    raw_n = '1;
    push(6, "all_rel", '1, '0, '0, '1, 1'b0);
    push(7, "all_idle", '1, '0, '0, '0, 1'b0);
    tick(8);

    // Reset pulsed after two counting edges on bit 5 discards the count.
    raw_n[5] = 1'b0;
    for (int d = 1; d <= 5; d++) push(d, "mid5_pre", B5, '0, '0, '0, 1'b0);
    tick(4);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    for (int d = 1; d <= 5; d++) push(d, "mid5_wait", B5, '0, '0, '0, 1'b0);
    push(6, "mid5_edge", B5, B5, B5, '0, 1'b1);
    push(7, "mid5_after", B5, B5, '0, '0, 1'b0);
    tick(10);

    for (int i = 0; i < sb.size(); i++) check({"expired_", sb[i].tag}, 16'd0, 16'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
